// File: rtl/zbt_audio_pkg.sv
// Shared constants and types for the ZBT audio sample path.
//   SAMPLE_W : bits per AC97 sample
//   WORD_W   : ZBT data width (three samples per word)
//   ADDR_W   : ZBT address width
//   READ_LAT : cycles from read issue to valid ZBT read data
package zbt_audio_pkg;

    localparam int SAMPLE_W = 12;
    localparam int WORD_W   = 36;
    localparam int ADDR_W   = 19;
    localparam int READ_LAT = 2;

    // Position of a sample within its three-sample group (0..2).
    typedef logic [1:0] slot_t;

    localparam slot_t SLOT_LAST = 2'd2;

    typedef enum logic {
        MODE_PLAY = 1'b0,
        MODE_REC  = 1'b1
    } mode_t;

    function automatic slot_t next_slot(input slot_t s);
        return (s == SLOT_LAST) ? 2'd0 : s + 2'd1;
    endfunction

endpackage

// File: rtl/zbt_sample_packer_if.sv
// ZBT SRAM port bundle.
//   master : driven by the sample packer (address, write strobe, write data)
//   slave  : the SRAM side, returns read data
interface zbt_sample_packer_if #(
    parameter int ADDR_W = zbt_audio_pkg::ADDR_W,
    parameter int WORD_W = zbt_audio_pkg::WORD_W
);
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [WORD_W-1:0] ram_write_data;
    logic [WORD_W-1:0] ram_read_data;

    modport master (
        output ram_addr,
        output ram_we,
        output ram_write_data,
        input  ram_read_data
    );

    modport slave (
        input  ram_addr,
        input  ram_we,
        input  ram_write_data,
        output ram_read_data
    );
endinterface

// File: rtl/zbt_read_pipe.sv
// Valid-token delay line matching the ZBT read latency.
//   clk        : system clock
//   reset      : asynchronous active-high clear
//   flush      : synchronous clear, drops any in-flight token
//   push       : token enters on the cycle the read address is on the bus
//   data_valid : one-cycle pulse, LAT cycles after push, when read data is valid
module zbt_read_pipe #(
    parameter int LAT = zbt_audio_pkg::READ_LAT
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic push,
    output logic data_valid
);

    logic [LAT-1:0] stage_reg;
    logic [LAT:0]   tap;

    assign tap        = {stage_reg, push};
    assign data_valid = stage_reg[LAT-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_reg <= '0;
        end else if (flush) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= tap[LAT-1:0];
        end
    end

endmodule

// File: rtl/zbt_sample_packer.sv
// Packs three 12-bit AC97 samples per 36-bit ZBT word in record mode and
// unpacks them in playback, following the address calculator's group cadence.
//   clk, reset  : system clock, asynchronous active-high reset
//   ready       : AC97 sample slot strobe
//   record_mode : 1 = record, 0 = playback; latched on start_song
//   start_song  : restart the group sequence
//   pause_song  : freeze sample acceptance
//   song_done   : end of song, freeze sample acceptance
//   mem_address : current group address from the address calculator
//   from_ac97   : record sample
//   to_ac97     : playback sample
//   ram         : ZBT port (address, write pulse, write data, read data)
module zbt_sample_packer #(
    parameter int SAMPLE_W = zbt_audio_pkg::SAMPLE_W,
    parameter int WORD_W   = zbt_audio_pkg::WORD_W,
    parameter int ADDR_W   = zbt_audio_pkg::ADDR_W,
    parameter int READ_LAT = zbt_audio_pkg::READ_LAT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ready,
    input  logic                record_mode,
    input  logic                start_song,
    input  logic                pause_song,
    input  logic                song_done,
    input  logic [ADDR_W-1:0]   mem_address,
    input  logic [SAMPLE_W-1:0] from_ac97,
    output logic [SAMPLE_W-1:0] to_ac97,
    zbt_sample_packer_if.master ram
);

    import zbt_audio_pkg::slot_t;
    import zbt_audio_pkg::mode_t;
    import zbt_audio_pkg::MODE_PLAY;
    import zbt_audio_pkg::MODE_REC;
    import zbt_audio_pkg::next_slot;

    slot_t                 slot_reg;
    mode_t                 mode_reg;
    logic [ADDR_W-1:0]     grp_addr_reg;
    logic [2*SAMPLE_W-1:0] pack_reg;      // slots 0 and 1 waiting for slot 2
    logic [WORD_W-1:0]     rd_buf_reg;
    logic [SAMPLE_W-1:0]   to_ac97_reg;
    logic [ADDR_W-1:0]     ram_addr_reg;
    logic                  ram_we_reg;
    logic [WORD_W-1:0]     ram_write_data_reg;
    logic                  rd_issue_reg;  // high on the cycle the read address is on the bus
    logic                  rd_valid;
    logic                  accept;

    // start_song outranks ready so the calculator and this stage restart together.
    assign accept = ready & ~pause_song & ~song_done & ~start_song;

    assign to_ac97            = to_ac97_reg;
    assign ram.ram_addr       = ram_addr_reg;
    assign ram.ram_we         = ram_we_reg;
    assign ram.ram_write_data = ram_write_data_reg;

    zbt_read_pipe #(.LAT(READ_LAT)) u_read_pipe (
        .clk        (clk),
        .reset      (reset),
        .flush      (start_song),
        .push       (rd_issue_reg),
        .data_valid (rd_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_reg           <= 2'd0;
            mode_reg           <= MODE_PLAY;
            grp_addr_reg       <= '0;
            pack_reg           <= '0;
            rd_buf_reg         <= '0;
            to_ac97_reg        <= '0;
            ram_addr_reg       <= '0;
            ram_we_reg         <= 1'b0;
            ram_write_data_reg <= '0;
            rd_issue_reg       <= 1'b0;
        end else begin
            ram_we_reg   <= 1'b0;
            rd_issue_reg <= 1'b0;
            if (start_song) begin
                // A partially filled record group is simply abandoned here.
                slot_reg    <= 2'd0;
                mode_reg    <= mode_t'(record_mode);
                pack_reg    <= '0;
                to_ac97_reg <= '0;
            end else begin
                if (rd_valid) begin
                    rd_buf_reg  <= ram.ram_read_data;
                    to_ac97_reg <= ram.ram_read_data[SAMPLE_W-1:0];
                end
                if (accept) begin
                    slot_reg <= next_slot(slot_reg);
                    // The calculator moves on next cycle, so this is the group address.
                    if (slot_reg == 2'd0) begin
                        grp_addr_reg <= mem_address;
                    end
                    if (mode_reg == MODE_REC) begin
                        case (slot_reg)
                            2'd0: pack_reg[SAMPLE_W-1:0]          <= from_ac97;
                            2'd1: pack_reg[2*SAMPLE_W-1:SAMPLE_W] <= from_ac97;
                            2'd2: begin
                                ram_we_reg         <= 1'b1;
                                ram_addr_reg       <= grp_addr_reg;
                                ram_write_data_reg <= {from_ac97, pack_reg};
                            end
                            default: ;
                        endcase
                    end else begin
                        case (slot_reg)
                            2'd0: begin
                                ram_addr_reg <= mem_address;
                                rd_issue_reg <= 1'b1;
                            end
                            2'd1: to_ac97_reg <= rd_buf_reg[2*SAMPLE_W-1:SAMPLE_W];
                            2'd2: to_ac97_reg <= rd_buf_reg[3*SAMPLE_W-1:2*SAMPLE_W];
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

endmodule
